// File: rtl/ccmp_in_reg.sv
// ccmp_in_reg -- input buffer of the CCMP engine.
//
// Packs the 8-bit payload byte stream coming from the Tx/Rx FIFO into
// 128-bit blocks for the AES/CCM core. The first byte of a block lands in
// ccmInData[7:0]. Every block carries a valid-byte count (minus one) and a
// last-block flag. A partial final block is zero-padded because the buffer
// is cleared whenever a block is handed over.
//
// Ports
//   pClk, nPRst          clock, asynchronous active-low reset
//   nSRst                synchronous active-low software reset
//   rxError_p,tcTxErrorP error pulses, flush the buffer on the next edge
//   byteIn/Valid/Last    byte stream from the FIFO
//   byteInReady          buffer can take a byte this cycle
//   ccmInData/Len/Last   block towards the CCM core, held while ccmInValid
//   ccmInValid           block held and valid (level)
//   ccmInAccept_p        CCM core takes the block (one-cycle pulse)
//
// Configuration
//   CCMP_IN_DOUBLE_BUF_EN  when defined, a second 128-bit holding register
//                          drives the ccmIn* outputs so the next block can
//                          fill while the previous one waits for the core.
//                          Undefined (default): single buffer.

module ccmp_in_reg (
  input  logic         pClk,
  input  logic         nPRst,
  input  logic         nSRst,
  input  logic         rxError_p,
  input  logic         tcTxErrorP,
  input  logic [7:0]   byteIn,
  input  logic         byteInValid,
  input  logic         byteInLast,
  output logic         byteInReady,
  output logic [127:0] ccmInData,
  output logic         ccmInValid,
  output logic [3:0]   ccmInLen,
  output logic         ccmInLast,
  input  logic         ccmInAccept_p
);

  // FILL: collecting bytes; FULL: fill buffer complete and waiting
  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] ptr;

  // Error pulses and the software reset share one synchronous clear path;
  // it wins over any transfer or accept in the same cycle.
  logic flush;
  logic xfer;
  logic block_done;

  assign flush      = rxError_p | tcTxErrorP | ~nSRst;
  assign xfer       = byteInValid & byteInReady;
  assign block_done = xfer & ((ptr == 4'hF) | byteInLast);

`ifdef CCMP_IN_DOUBLE_BUF_EN

  logic [127:0] fill_data;
  logic [127:0] fill_next;
  logic [3:0]   fill_len;
  logic         fill_last;
  logic         hold_free;

  // The holding register can be loaded this cycle if empty or being taken now.
  assign hold_free = ~ccmInValid | ccmInAccept_p;

  // Fill buffer with the incoming byte merged into lane ptr.
  always_comb begin
    fill_next                     = fill_data;
    fill_next[{ptr, 3'b000} +: 8] = byteIn;
  end

  // Fill/hold sequencing and registered outputs.
  always_ff @(posedge pClk or negedge nPRst) begin
    if (!nPRst) begin
      state       <= FILL;
      ptr         <= 4'h0;
      fill_data   <= 128'h0;
      fill_len    <= 4'h0;
      fill_last   <= 1'b0;
      byteInReady <= 1'b1;
      ccmInData   <= 128'h0;
      ccmInValid  <= 1'b0;
      ccmInLen    <= 4'h0;
      ccmInLast   <= 1'b0;
    end else if (flush) begin
      state       <= FILL;
      ptr         <= 4'h0;
      fill_data   <= 128'h0;
      fill_len    <= 4'h0;
      fill_last   <= 1'b0;
      byteInReady <= 1'b1;
      ccmInData   <= 128'h0;
      ccmInValid  <= 1'b0;
      ccmInLen    <= 4'h0;
      ccmInLast   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (block_done) begin
            ptr <= 4'h0;
            if (hold_free) begin
              // Completed block bypasses straight into the holding register.
              ccmInData  <= fill_next;
              ccmInLen   <= ptr;
              ccmInLast  <= byteInLast;
              ccmInValid <= 1'b1;
              fill_data  <= 128'h0;
            end else begin
              fill_data   <= fill_next;
              fill_len    <= ptr;
              fill_last   <= byteInLast;
              state       <= FULL;
              byteInReady <= 1'b0;
            end
          end else begin
            if (xfer) begin
              fill_data <= fill_next;
              ptr       <= ptr + 4'd1;
            end
            if (ccmInAccept_p) begin
              ccmInData  <= 128'h0;
              ccmInValid <= 1'b0;
              ccmInLen   <= 4'h0;
              ccmInLast  <= 1'b0;
            end
          end
        end
        FULL: begin
          // Holding register is occupied here; an accept swaps in the fill block.
          if (ccmInAccept_p) begin
            ccmInData   <= fill_data;
            ccmInLen    <= fill_len;
            ccmInLast   <= fill_last;
            ccmInValid  <= 1'b1;
            fill_data   <= 128'h0;
            fill_len    <= 4'h0;
            fill_last   <= 1'b0;
            state       <= FILL;
            byteInReady <= 1'b1;
          end
        end
        default: begin
          state       <= FILL;
          byteInReady <= 1'b1;
        end
      endcase
    end
  end

`else

  // Single-buffer FSM; ccmInData is the packing register itself.
  always_ff @(posedge pClk or negedge nPRst) begin
    if (!nPRst) begin
      state       <= FILL;
      ptr         <= 4'h0;
      byteInReady <= 1'b1;
      ccmInData   <= 128'h0;
      ccmInValid  <= 1'b0;
      ccmInLen    <= 4'h0;
      ccmInLast   <= 1'b0;
    end else if (flush) begin
      state       <= FILL;
      ptr         <= 4'h0;
      byteInReady <= 1'b1;
      ccmInData   <= 128'h0;
      ccmInValid  <= 1'b0;
      ccmInLen    <= 4'h0;
      ccmInLast   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (xfer) begin
            ccmInData[{ptr, 3'b000} +: 8] <= byteIn;
            if (block_done) begin
              state       <= FULL;
              ccmInLen    <= ptr;
              ccmInLast   <= byteInLast;
              ccmInValid  <= 1'b1;
              byteInReady <= 1'b0;
              ptr         <= 4'h0;
            end else begin
              ptr <= ptr + 4'd1;
            end
          end
        end
        FULL: begin
          // Clearing on hand-over is what zero-pads the next partial block.
          if (ccmInAccept_p) begin
            state       <= FILL;
            ccmInData   <= 128'h0;
            ccmInValid  <= 1'b0;
            ccmInLen    <= 4'h0;
            ccmInLast   <= 1'b0;
            byteInReady <= 1'b1;
          end
        end
        default: begin
          state       <= FILL;
          byteInReady <= 1'b1;
        end
      endcase
    end
  end

`endif

endmodule
